// File: rtl/send_control_multi.sv
//------------------------------------------------------------------------------
// send_control_multi
//   Frame-send sequencer for the 125 MHz Ethernet TX path. Issues one-cycle
//   start_sending pulses to the frame builder and tags every frame with the
//   segment index, the redundancy copy index, the round counter and a global
//   successful-frame ID. Supports programmable redundancy, a programmable
//   inter-frame gap and a busy-acknowledge timeout with retry. Configuration
//   is latched only when leaving IDLE.
//
// Ports
//   clk125MHz     in   system clock, rising edge
//   rstn          in   asynchronous active-low reset
//   enable        in   run request
//   max_segment   in   last segment index of a round (0 = single segment)
//   redundancy    in   copies per segment (0 -> 1, >MAX_REDUN -> MAX_REDUN)
//   gap_cycles    in   idle cycles between frames (0 behaves as 1)
//   busy          in   frame builder busy
//   start_sending out  one-cycle frame start pulse
//   segment_num   out  current segment index
//   txid_inter    out  copy index within the segment
//   aux           out  round counter (wraps)
//   txid          out  successful-frame counter (wraps)
//   round_done    out  one-cycle pulse when a round completes
//   timeout_err   out  one-cycle pulse on ack timeout
//------------------------------------------------------------------------------
module send_control_multi #(
   parameter int SEG_W       = 16,
   parameter int ID_W        = 8,
   parameter int MAX_REDUN   = 4,
   parameter int GAP_W       = 16,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic             clk125MHz,
   input  logic             rstn,
   input  logic             enable,
   input  logic [SEG_W-1:0] max_segment,
   input  logic [ID_W-1:0]  redundancy,
   input  logic [GAP_W-1:0] gap_cycles,
   input  logic             busy,
   output logic             start_sending,
   output logic [SEG_W-1:0] segment_num,
   output logic [ID_W-1:0]  txid_inter,
   output logic [ID_W-1:0]  aux,
   output logic [ID_W-1:0]  txid,
   output logic             round_done,
   output logic             timeout_err
);

   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   // MAX_REDUN may be 2^ID_W, so the clamp works one bit wider than ID_W
   localparam logic [ID_W:0] MAX_R = (ID_W + 1)'(MAX_REDUN);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } state_t;

   state_t state, state_nxt;

   // latched configuration; copies are stored as copies-1 so they fit ID_W
   logic [SEG_W-1:0] max_seg_lat;
   logic [ID_W-1:0]  copies_m1_lat;
   logic [GAP_W-1:0] gap_lat;

   logic [ACK_W-1:0] ack_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic [ID_W:0]    red_ext;
   logic [ID_W:0]    copies_in;
   logic [ID_W-1:0]  copies_m1_in;

   logic             idle_exit;
   logic             ack_hit;
   logic             done_hit;
   logic             gap_done;
   logic             last_copy;
   logic             last_seg;

   //---------------------------------------------------------------------------
   // Redundancy clamp
   //---------------------------------------------------------------------------
   always_comb begin
      red_ext = {1'b0, redundancy};
      if (redundancy == '0)
         copies_in = (ID_W + 1)'(1);
      else if (red_ext > MAX_R)
         copies_in = MAX_R;
      else
         copies_in = red_ext;
      copies_m1_in = ID_W'(copies_in - (ID_W + 1)'(1));
   end

   //---------------------------------------------------------------------------
   // Qualified events
   //---------------------------------------------------------------------------
   assign idle_exit = (state == IDLE) && enable && !busy;
   // the timeout fires on the ACK_TIMEOUT-th consecutive idle-busy cycle
   assign ack_hit   = (state == WAIT_BUSY) && !busy && (ack_cnt == ACK_LAST);
   assign done_hit  = (state == WAIT_DONE) && !busy;
   assign gap_done  = (gap_cnt == '0);
   assign last_copy = (txid_inter == copies_m1_lat);
   assign last_seg  = (segment_num == max_seg_lat);

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk125MHz or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   //---------------------------------------------------------------------------
   // FSM: next state
   //---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (idle_exit)
               state_nxt = START;
         end
         START: begin
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (busy)
               state_nxt = WAIT_DONE;
            else if (ack_hit)
               state_nxt = GAP;
         end
         WAIT_DONE: begin
            if (!busy)
               state_nxt = GAP;
         end
         GAP: begin
            if (gap_done)
               state_nxt = enable ? START : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: outputs
   //---------------------------------------------------------------------------
   always_comb begin
      start_sending = (state == START);
   end

   //---------------------------------------------------------------------------
   // Config latch
   //---------------------------------------------------------------------------
   always_ff @(posedge clk125MHz or negedge rstn) begin
      if (!rstn) begin
         max_seg_lat   <= '0;
         copies_m1_lat <= '0;
         gap_lat       <= '0;
      end else if (idle_exit) begin
         max_seg_lat   <= max_segment;
         copies_m1_lat <= copies_m1_in;
         gap_lat       <= gap_cycles;
      end
   end

   //---------------------------------------------------------------------------
   // Ack timer: cleared while START is presented, counts idle-busy cycles
   //---------------------------------------------------------------------------
   always_ff @(posedge clk125MHz or negedge rstn) begin
      if (!rstn)
         ack_cnt <= '0;
      else if (state == START)
         ack_cnt <= '0;
      else if ((state == WAIT_BUSY) && !busy && !ack_hit)
         ack_cnt <= ack_cnt + ACK_W'(1);
   end

   //---------------------------------------------------------------------------
   // Gap timer: loaded on GAP entry with the remaining cycles after the first,
   // so gap_cycles of 0 and 1 both give a single GAP cycle
   //---------------------------------------------------------------------------
   always_ff @(posedge clk125MHz or negedge rstn) begin
      if (!rstn)
         gap_cnt <= '0;
      else if (ack_hit || done_hit)
         gap_cnt <= (gap_lat == '0) ? '0 : gap_lat - GAP_W'(1);
      else if ((state == GAP) && !gap_done)
         gap_cnt <= gap_cnt - GAP_W'(1);
   end

   //---------------------------------------------------------------------------
   // Frame tag counters and status pulses. Counters only move on a completed
   // frame; a timed-out frame is retried with its tag unchanged.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk125MHz or negedge rstn) begin
      if (!rstn) begin
         segment_num <= '0;
         txid_inter  <= '0;
         aux         <= '0;
         txid        <= '0;
         round_done  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         round_done  <= 1'b0;
         timeout_err <= ack_hit;
         if (done_hit) begin
            txid <= txid + ID_W'(1);
            if (last_copy) begin
               txid_inter <= '0;
               if (last_seg) begin
                  segment_num <= '0;
                  aux         <= aux + ID_W'(1);
                  round_done  <= 1'b1;
               end else begin
                  segment_num <= segment_num + SEG_W'(1);
               end
            end else begin
               txid_inter <= txid_inter + ID_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/send_control_multi.md
Name: send_control_multi

Overview:
- Parametrised next-generation frame-send sequencer for the 125 MHz Ethernet TX path.
- Issues one-cycle start_sending pulses to the frame builder and tags each frame with segment number, redundancy copy index, round counter and a global frame ID.
- Adds programmable redundancy, a programmable inter-frame gap, a busy-acknowledge timeout with retry, and config latching.

Parameters:
- SEG_W, 16: width of segment_num and max_segment.
- ID_W, 8: width of txid, txid_inter and aux.
- MAX_REDUN, 4: maximum copies per segment (1..2^ID_W).
- GAP_W, 16: width of the gap_cycles counter.
- ACK_TIMEOUT, 64: cycles to wait for busy to rise after start_sending.

Ports:
- clk125MHz  in  1  system clock, all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  run request.
- max_segment  in  SEG_W  last segment index of a round (0 = single segment).
- redundancy  in  ID_W  copies per segment; 0 is treated as 1; values >MAX_REDUN are clamped to MAX_REDUN.
- gap_cycles  in  GAP_W  idle cycles between frames.
- busy  in  1  frame builder busy.
- start_sending  out  1  one-cycle frame start pulse.
- segment_num  out  SEG_W  current segment index.
- txid_inter  out  ID_W  copy index within the segment, 0..copies-1.
- aux  out  ID_W  round counter, wraps.
- txid  out  ID_W  successful-frame counter, wraps.
- round_done  out  1  one-cycle pulse when the last copy of segment max_segment completes.
- timeout_err  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset (rstn=0, asynchronous): state IDLE, all outputs and counters 0, latched config 0.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If enable=1 and busy=0: latch max_segment, clamped redundancy (copies) and gap_cycles, then go to START.
  - Otherwise stay in IDLE.
  - Counters are not cleared in IDLE; only reset clears them.
- START:
  - start_sending=1 for exactly this one cycle.
  - Go to WAIT_BUSY.
  - segment_num, txid_inter, aux and txid are stable from START until the counter advance.
- WAIT_BUSY:
  - busy is sampled from the cycle after START.
  - busy=1: go to WAIT_DONE.
  - ACK_TIMEOUT consecutive cycles with busy=0: pulse timeout_err, go to GAP without advancing counters. The same frame is retried.
- WAIT_DONE:
  - busy=0: advance counters in the same edge, then go to GAP.
- Counter advance:
  - txid += 1 (wraps).
  - If txid_inter == copies-1: txid_inter = 0 and the segment advances. Otherwise txid_inter += 1.
  - Segment advance: if segment_num == max_segment, then segment_num = 0, aux += 1 (wraps) and round_done pulses in the same cycle. Otherwise segment_num += 1.
- GAP:
  - Count gap_cycles cycles, then go to START if enable=1, else IDLE.
  - gap_cycles=0: leave GAP after exactly one cycle. Consecutive start_sending pulses are therefore separated by at least (busy duration + 3) cycles.
- Config changes while not in IDLE are ignored until the next IDLE exit.
- enable=0 mid-frame: the current frame completes WAIT_DONE and GAP, then the block goes to IDLE. No start_sending is issued after enable is seen low in GAP.
- Timeout during the last copy of a round does not pulse round_done.
- Reset asserted mid-frame returns to IDLE immediately, with no pulses on release.

Test Plan:
- Reset then enable=1, max_segment=2, redundancy=1, gap_cycles=0; model busy high 10 cycles after each start:
  - Required: segment_num sequence 0,1,2,0; aux increments to 1 after the third frame; round_done pulses once; txid=3.
- redundancy=3, max_segment=1:
  - Required: (segment_num, txid_inter) sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) and then aux=1.
- redundancy=0, and separately redundancy=9 with MAX_REDUN=4:
  - Required: copies behave as 1 and 4 respectively.
- busy held 0 after start_sending:
  - Required: timeout_err pulses 64 cycles after the cycle following START; after the gap, start_sending repeats with unchanged segment_num, txid_inter and txid.
- gap_cycles=20:
  - Required: exactly 20 GAP cycles between busy falling and the cycle before the next start_sending. Changing gap_cycles mid-run has no effect until re-entry from IDLE.
- enable dropped while busy=1, and separately rstn pulsed low mid-WAIT_DONE:
  - Required (enable drop): frame completes, counters advance once, the block reaches IDLE and no further pulses occur.
  - Required (reset): all outputs read 0 immediately.
